pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder_pkg.sv | 26 ++
 rtl/pe_feeder_regfile.sv | 41 ++++
 rtl/pe_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_pe_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg
//   Shared definitions for the PE feeder: FSM state encoding, default
//   parameter values and the configuration register address map.
package pe_feeder_pkg;

  localparam int DEF_D_WIDTH     = 32;
  localparam int DEF_IACT_SIZE   = 5;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_TIMEOUT     = 64;

  // Eight host-writable words: iact[0..4] followed by weight[0..2].
  localparam int         REG_COUNT = 8;
  localparam logic [2:0] IACT_BASE = 3'd0;
  localparam logic [2:0] W_BASE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SEND_IACT = 3'd2,
    ST_GAP       = 3'd3,
    ST_SEND_W    = 3'd4,
    ST_WAIT      = 3'd5,
    ST_RESULT    = 3'd6
  } state_t;

endpackage

// File: rtl/pe_feeder_regfile.sv
// feeder_regfile
//   Eight-entry configuration register file. Written by the host through a
//   single write port, read combinationally through two independent ports
//   (one for the iact stream, one for the weight stream).
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (clears all words)
//   we, waddr, wdata  host write port
//   raddr_a, rdata_a  combinational read port A
//   raddr_b, rdata_b  combinational read port B
module feeder_regfile
  import pe_feeder_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [2:0]         waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [2:0]         raddr_a,
  output logic [D_WIDTH-1:0] rdata_a,
  input  logic [2:0]         raddr_b,
  output logic [D_WIDTH-1:0] rdata_b
);

  logic [D_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder
//   Sequences one PE run: start pulse, iact stream, one-cycle gap, weight
//   stream, then waits (bounded by TIMEOUT) for the PE completion pulse,
//   captures the three result words and holds them until the host accepts.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_we, cfg_addr, cfg_wdata    host config writes (honoured in IDLE only)
//   go                             start request (honoured in IDLE only)
//   busy                           high whenever the FSM is not IDLE
//   pe_start, pe_iact, pe_weight   stimulus to the PE
//   pe_done, pe_out0..2            PE completion pulse and result words
//   res_valid, res_ready, res0..2  captured results and host handshake
//   err_timeout                    sticky: PE did not finish in time
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | accepts config writes and go
// ST_START     | one-cycle pe_start pulse
// ST_SEND_IACT | streams iact[0..IACT_SIZE-1], one word per cycle
// ST_GAP       | one idle cycle for the PE's load-to-weight switch
// ST_SEND_W    | streams weight[0..KERNEL_SIZE-1], one word per cycle
// ST_WAIT      | waits for pe_done, bounded by TIMEOUT cycles
// ST_RESULT    | res_valid held until res_ready
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int IACT_SIZE   = DEF_IACT_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_wdata,
  input  logic               go,
  output logic               busy,
  output logic               pe_start,
  output logic [D_WIDTH-1:0] pe_iact,
  output logic [D_WIDTH-1:0] pe_weight,
  input  logic               pe_done,
  input  logic [D_WIDTH-1:0] pe_out0,
  input  logic [D_WIDTH-1:0] pe_out1,
  input  logic [D_WIDTH-1:0] pe_out2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [D_WIDTH-1:0] res0,
  output logic [D_WIDTH-1:0] res1,
  output logic [D_WIDTH-1:0] res2,
  output logic               err_timeout
);

  localparam int SEND_MAX = (IACT_SIZE > KERNEL_SIZE) ? IACT_SIZE : KERNEL_SIZE;
  localparam int SCW      = (SEND_MAX > 1) ? $clog2(SEND_MAX) : 1;
  localparam int WCW      = $clog2(TIMEOUT + 1);

  localparam logic [SCW-1:0] IACT_LAST = SCW'(IACT_SIZE - 1);
  localparam logic [SCW-1:0] W_LAST    = SCW'(KERNEL_SIZE - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [SCW-1:0]     snd_cnt;
  logic [WCW-1:0]     wait_cnt;
  logic [D_WIDTH-1:0] iact_rd, weight_rd;
  logic [2:0]         iact_raddr, weight_raddr;

  logic cfg_wr, run_init, snd_inc, snd_clr, wait_inc, capture, set_err;

  // One counter serves both send windows; it is cleared at the end of each.
  assign iact_raddr   = IACT_BASE + 3'(snd_cnt);
  assign weight_raddr = W_BASE + 3'(snd_cnt);

  feeder_regfile #(
    .D_WIDTH (D_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_wr),
    .waddr   (cfg_addr),
    .wdata   (cfg_wdata),
    .raddr_a (iact_raddr),
    .rdata_a (iact_rd),
    .raddr_b (weight_raddr),
    .rdata_b (weight_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_wr    = 1'b0;
    run_init  = 1'b0;
    snd_inc   = 1'b0;
    snd_clr   = 1'b0;
    wait_inc  = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_wr = cfg_we;
        if (go) begin
          run_init  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        state_nxt = ST_SEND_IACT;
      end
      ST_SEND_IACT: begin
        if (snd_cnt == IACT_LAST) begin
          snd_clr   = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          snd_inc = 1'b1;
        end
      end
      ST_GAP: begin
        state_nxt = ST_SEND_W;
      end
      ST_SEND_W: begin
        if (snd_cnt == W_LAST) begin
          snd_clr   = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          snd_inc = 1'b1;
        end
      end
      ST_WAIT: begin
        // pe_done wins over a timeout landing on the same cycle.
        if (pe_done) begin
          capture   = 1'b1;
          state_nxt = ST_RESULT;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snd_cnt     <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      res0        <= '0;
      res1        <= '0;
      res2        <= '0;
    end else begin
      if (run_init || snd_clr) begin
        snd_cnt <= '0;
      end else if (snd_inc) begin
        snd_cnt <= snd_cnt + 1'b1;
      end

      if (run_init) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (run_init) begin
        err_timeout <= 1'b0;
      end else if (set_err) begin
        err_timeout <= 1'b1;
      end

      // PE words are passed through untouched; accumulation across runs
      // happens inside the PE.
      if (capture) begin
        res0 <= pe_out0;
        res1 <= pe_out1;
        res2 <= pe_out2;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign pe_start  = (state == ST_START);
  assign pe_iact   = (state == ST_SEND_IACT) ? iact_rd   : '0;
  assign pe_weight = (state == ST_SEND_W)    ? weight_rd : '0;
  assign res_valid = (state == ST_RESULT);

endmodule

// File: tb/tb_pe_feeder.sv
module tb_pe_feeder;

  localparam int DW = 32;
  localparam int NI = 5;
  localparam int NK = 3;
  localparam int TO = 64;

  logic          clk, rst_n, cfg_we, go, pe_done, res_ready;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata, pe_iact, pe_weight, pe_out0, pe_out1, pe_out2;
  logic [DW-1:0] res0, res1, res2;
  logic          busy, pe_start, res_valid, err_timeout;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: configured contents and expected PE accumulators
  logic [DW-1:0] m_iact [NI];
  logic [DW-1:0] m_w    [NK];
  logic [DW-1:0] m_acc  [3];

  // behavioural PE attached to the feeder
  logic          pe_en = 1'b0;
  logic          stub_done = 1'b0;
  logic          stray_done = 1'b0;
  logic          armed = 1'b0;
  int            pos = 0;
  int            pe_lat = 1;
  int            start_cnt = 0;
  logic [DW-1:0] cap_i [NI] = '{default: '0};
  logic [DW-1:0] cap_w [NK] = '{default: '0};
  logic [DW-1:0] acc   [3]  = '{default: '0};

  assign pe_done = stub_done | stray_done;
  assign pe_out0 = acc[0];
  assign pe_out1 = acc[1];
  assign pe_out2 = acc[2];

  pe_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .go          (go),
    .busy        (busy),
    .pe_start    (pe_start),
    .pe_iact     (pe_iact),
    .pe_weight   (pe_weight),
    .pe_done     (pe_done),
    .pe_out0     (pe_out0),
    .pe_out1     (pe_out1),
    .pe_out2     (pe_out2),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res0        (res0),
    .res1        (res1),
    .res2        (res2),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] stub_dot(int j);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < NK; k++) s = s + cap_i[j+k] * cap_w[k];
    return s;
  endfunction

  // PE: captures the stream by position after pe_start, accumulates, then
  // pulses pe_done pe_lat cycles after the last weight.
  always @(negedge clk) begin
    stub_done <= 1'b0;
    if (pe_start) start_cnt <= start_cnt + 1;
    if (!rst_n || !pe_en) begin
      armed <= 1'b0;
    end else if (pe_start) begin
      armed <= 1'b1;
      pos   <= 0;
    end else if (armed) begin
      pos <= pos + 1;
      if (pos < NI) cap_i[pos] <= pe_iact;
      else if (pos >= NI + 1 && pos <= NI + NK) cap_w[pos-NI-1] <= pe_weight;
      if (pos == NI + NK + 1) begin
        for (int j = 0; j < 3; j++) acc[j] <= acc[j] + stub_dot(j);
      end
      if (pos == NI + NK + 1 + pe_lat) begin
        stub_done <= 1'b1;
        armed     <= 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one PE run = 1-D convolution of iact with weight, added to the PE state
  task automatic model_run();
    for (int j = 0; j < 3; j++) begin
      logic [DW-1:0] s = '0;
      for (int k = 0; k < NK; k++) s = s + m_iact[j+k] * m_w[k];
      m_acc[j] = m_acc[j] + s;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [DW-1:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NI; i++) cfg_write(3'(i), m_iact[i]);
    for (int k = 0; k < NK; k++) cfg_write(3'(5 + k), m_w[k]);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    while (!res_valid && t < 200) begin
      tick();
      t++;
    end
    chk({tag, " res_valid"}, res_valid, 1'b1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, " res0"}, res0, m_acc[0]);
    chk({tag, " res1"}, res1, m_acc[1]);
    chk({tag, " res2"}, res2, m_acc[2]);
    chk({tag, " err"}, err_timeout, 1'b0);
  endtask

  task automatic check_stream(input string tag);
    for (int i = 0; i < NI; i++) chk($sformatf("%s iact%0d", tag, i), cap_i[i], m_iact[i]);
    for (int k = 0; k < NK; k++) chk($sformatf("%s w%0d", tag, k), cap_w[k], m_w[k]);
  endtask

  task automatic accept(input string tag, input int rdelay);
    for (int i = 0; i < rdelay; i++) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, " valid clr"}, res_valid, 1'b0);
    chk({tag, " busy clr"}, busy, 1'b0);
  endtask

  task automatic run_simple(input string tag, input int lat, input int rdelay, input bit early);
    pe_lat = lat;
    if (early) res_ready = 1'b1;
    pulse_go();
    model_run();
    wait_result(tag);
    check_results(tag);
    check_stream(tag);
    if (early) begin
      tick();
      res_ready = 1'b0;
      chk({tag, " early valid clr"}, res_valid, 1'b0);
      chk({tag, " early busy clr"}, busy, 1'b0);
    end else begin
      accept(tag, rdelay);
    end
  endtask

  initial begin
    int s0;
    logic seen_valid;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    go = 1'b0; res_ready = 1'b0;
    for (int j = 0; j < 3; j++) m_acc[j] = '0;
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst pe_start", pe_start, 1'b0);
    chk("rst pe_iact", pe_iact, '0);
    chk("rst pe_weight", pe_weight, '0);
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst err", err_timeout, 1'b0);
    chk("rst res0", res0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pe_en = 1'b1;

    // directed run with cycle-exact stream checks
    for (int i = 0; i < NI; i++) m_iact[i] = DW'(i + 1);
    for (int k = 0; k < NK; k++) m_w[k] = 1;
    load_all();
    pe_lat = 3;
    s0 = start_cnt;
    pulse_go();
    model_run();
    chk("C1 pe_start", pe_start, 1'b1);
    chk("C1 busy", busy, 1'b1);
    chk("C1 pe_iact", pe_iact, '0);
    for (int k = 0; k < NI; k++) begin
      tick();
      chk($sformatf("C%0d pe_iact", k + 2), pe_iact, m_iact[k]);
      chk($sformatf("C%0d pe_weight", k + 2), pe_weight, '0);
      chk($sformatf("C%0d pe_start", k + 2), pe_start, 1'b0);
    end
    tick();
    chk("C7 gap iact", pe_iact, '0);
    chk("C7 gap weight", pe_weight, '0);
    for (int k = 0; k < NK; k++) begin
      tick();
      chk($sformatf("C%0d pe_weight", k + 8), pe_weight, m_w[k]);
      chk($sformatf("C%0d pe_iact", k + 8), pe_iact, '0);
    end
    tick();
    chk("C11 busy", busy, 1'b1);
    chk("C11 weight", pe_weight, '0);
    wait_result("run1");
    chk("run1 res0 const", res0, 6);
    chk("run1 res1 const", res1, 9);
    chk("run1 res2 const", res2, 12);
    check_results("run1");
    chk("run1 one start", start_cnt - s0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold valid", res_valid, 1'b1);
      chk("hold res0", res0, m_acc[0]);
      chk("hold res2", res2, m_acc[2]);
    end
    accept("run1", 0);

    // back-to-back, same data, host ready before the result
    run_simple("run2", 2, 0, 1'b1);
    chk("run2 res0 const", res0, 12);
    chk("run2 res1 const", res1, 18);
    chk("run2 res2 const", res2, 24);

    // stray pe_done in IDLE and res_ready without res_valid
    stray_done = 1'b1; res_ready = 1'b1;
    tick();
    stray_done = 1'b0; res_ready = 1'b0;
    tick();
    chk("stray busy", busy, 1'b0);
    chk("stray valid", res_valid, 1'b0);

    // cfg write and go during SEND_IACT are ignored
    pe_lat = 4;
    s0 = start_cnt;
    pulse_go();
    model_run();
    tick();
    cfg_addr = 3'd0; cfg_wdata = 99; cfg_we = 1'b1; go = 1'b1;
    tick();
    tick();
    cfg_we = 1'b0; go = 1'b0;
    wait_result("busycfg");
    check_results("busycfg");
    chk("busycfg iact0 old", cap_i[0], m_iact[0]);
    chk("busycfg one start", start_cnt - s0, 1);
    accept("busycfg", 1);
    run_simple("aftercfg", 1, 0, 1'b0);

    // timeout with the PE disconnected
    pe_en = 1'b0;
    pulse_go();
    repeat (10) tick();
    seen_valid = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (res_valid) seen_valid = 1'b1;
      if (i == TO - 1) begin
        chk("to early err", err_timeout, 1'b0);
        chk("to early busy", busy, 1'b1);
      end
    end
    chk("to err", err_timeout, 1'b1);
    chk("to idle", busy, 1'b0);
    chk("to never valid", seen_valid, 1'b0);
    tick();
    chk("to sticky", err_timeout, 1'b1);
    pe_en = 1'b1;
    pulse_go();
    chk("go clears err", err_timeout, 1'b0);
    model_run();
    wait_result("posterr");
    check_results("posterr");
    accept("posterr", 0);

    // reset in the middle of SEND_IACT
    pe_lat = 2;
    pulse_go();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst iact", pe_iact, '0);
    chk("midrst start", pe_start, 1'b0);
    chk("midrst valid", res_valid, 1'b0);
    chk("midrst err", err_timeout, 1'b0);
    chk("midrst res1", res1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) m_iact[i] = '0;
    for (int k = 0; k < NK; k++) m_w[k] = '0;
    run_simple("postrst", 2, 1, 1'b0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) m_iact[i] = DW'($urandom_range(0, 1000));
      for (int k = 0; k < NK; k++) m_w[k] = DW'($urandom_range(0, 1000));
      load_all();
      run_simple($sformatf("rnd%0d", r), $urandom_range(1, 20), $urandom_range(0, 5),
                 ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
